// File: rtl/mul_unit_seq.sv
// mul_unit_seq: multi-cycle shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//
// Ports:
//   Clock     in   1          rising-edge clock
//   Reset     in   1          synchronous, active-high
//   iStart    in   1          multiply request, accepted in IDLE or DONE
//   iSigned   in   1          1 = two's-complement operands, 0 = unsigned
//   iA        in   WIDTH      multiplicand (sampled with iStart)
//   iB        in   WIDTH      multiplier (sampled with iStart)
//   oBusy     out  1          high while a multiply is in progress
//   oDone     out  1          one-cycle pulse, oProduct/oOverflow valid
//   oProduct  out  2*WIDTH    full product, held until the next result
//   oOverflow out  1          product does not fit in WIDTH bits (mode-dependent)
//
// The unit multiplies magnitudes and applies the sign at the end, so signed
// and unsigned modes share one unsigned shift-add datapath.
module mul_unit_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oProduct,
  output logic                 oOverflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign;
  logic                 r_signed;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_overflow;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_acc_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_ovf;

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, acceptance and last-iteration decode.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (iStart) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_last       = 1'b1;
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE: begin
        // A start in the DONE cycle chains straight into the next multiply.
        if (iStart) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand magnitudes, accumulator step and final signed product/overflow.
  always_comb begin
    w_mag_a   = iA;
    w_mag_b   = iB;
    w_acc_sum = r_acc;
    w_prod    = ZERO_2W;
    w_ovf     = 1'b0;
    // The most negative value negates to itself, which reads correctly as
    // the unsigned magnitude 2^(WIDTH-1).
    if (iSigned && iA[WIDTH-1]) begin
      w_mag_a = ~iA + ONE_W;
    end else begin
      w_mag_a = iA;
    end
    if (iSigned && iB[WIDTH-1]) begin
      w_mag_b = ~iB + ONE_W;
    end else begin
      w_mag_b = iB;
    end
    if (r_mplier[0]) begin
      w_acc_sum = r_acc + r_mcand;
    end else begin
      w_acc_sum = r_acc;
    end
    // Negating a zero magnitude yields zero, so no special case is needed.
    if (r_sign) begin
      w_prod = ~w_acc_sum + ONE_2W;
    end else begin
      w_prod = w_acc_sum;
    end
    if (r_signed) begin
      w_ovf = (w_prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &&
              (w_prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
    end else begin
      w_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_mcand    <= ZERO_2W;
      r_mplier   <= {WIDTH{1'b0}};
      r_acc      <= ZERO_2W;
      r_cnt      <= {CW{1'b0}};
      r_sign     <= 1'b0;
      r_signed   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_product  <= ZERO_2W;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_acc    <= ZERO_2W;
      r_cnt    <= {CW{1'b0}};
      r_sign   <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
      r_signed <= iSigned;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + CNT_ONE;
      if (w_last) begin
        r_product  <= w_prod;
        r_overflow <= w_ovf;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
      end else begin
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign oBusy     = r_busy;
  assign oDone     = r_done;
  assign oProduct  = r_product;
  assign oOverflow = r_overflow;

endmodule
